// File: rtl/sr_sched_pkg.sv
// sr_sched_pkg
// Shared types and constants for the SR flag scheduler.
//   state_t      : scheduler FSM states
//   OP_SET/RST   : encoding of req_op
//   DEF_*        : default parameter values for sr_flag_sched
package sr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_NFLAG     = 8;
  localparam int DEF_PULSE_CYC = 2;

endpackage

// File: rtl/sr_flag_sched_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker: grants the first requester
// at or after i_ptr, wrapping modulo NREQ.
//   i_req     : request vector
//   i_ptr     : priority pointer (must be < NREQ)
//   o_gnt     : one-hot grant (zero when no request)
//   o_gnt_idx : encoded grant index (0 when no request)
//   o_any     : at least one request present
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_gnt_idx,
  output logic                    o_any
);

  localparam int GW = $clog2(NREQ);

  always_comb begin
    int j;
    j         = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    // Walk NREQ positions starting at the pointer; first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_req[j]) begin
        o_any     = 1'b1;
        o_gnt[j]  = 1'b1;
        o_gnt_idx = j[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_flag_sched.sv
// sr_flag_sched
// Round-robin scheduler that serialises set/clear requests onto a bank of
// gated SR flops, generating SETUP -> PULSE -> HOLD -> CHECK per operation
// and verifying the written value on readback.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/op/idx      : per-requester request (idx packed, req 0 in LSBs)
//   req_ready             : one-hot 1-cycle accept pulse
//   s_out, r_out, c_out   : set / reset / gate lines to the bank
//   q_in                  : bank Q readback
//   done, done_id         : completion pulse and the requester it belongs to
//   err                   : sticky readback mismatch
//   busy                  : high outside IDLE
module sr_flag_sched
  import sr_sched_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int NFLAG     = DEF_NFLAG,
  parameter int PULSE_CYC = DEF_PULSE_CYC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0]                 req_op,
  input  logic [NREQ*$clog2(NFLAG)-1:0]   req_idx,
  output logic [NREQ-1:0]                 req_ready,
  output logic [NFLAG-1:0]                s_out,
  output logic [NFLAG-1:0]                r_out,
  output logic                            c_out,
  input  logic [NFLAG-1:0]                q_in,
  output logic                            done,
  output logic [$clog2(NREQ)-1:0]         done_id,
  output logic                            err,
  output logic                            busy
);

  localparam int IW = $clog2(NFLAG);
  localparam int GW = $clog2(NREQ);
  localparam logic [NFLAG-1:0] ONE_HOT0 = NFLAG'(1);

  state_t          r_state;
  state_t          w_state_next;
  logic [GW-1:0]   r_ptr;
  logic            r_op;
  logic [IW-1:0]   r_idx;
  logic [GW-1:0]   r_gid;
  logic [3:0]      r_cnt;
  logic            r_err;

  logic [NREQ-1:0] w_gnt;
  logic [GW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [NFLAG-1:0] w_vec;
  logic            w_mis;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_vec = ONE_HOT0 << r_idx;
  // Mismatch is visible in the CHECK cycle itself, then held in r_err.
  assign w_mis = (r_state == CHECK) && (q_in[r_idx] != r_op);
  assign err   = r_err | w_mis;
  assign busy  = (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    s_out        = '0;
    r_out        = '0;
    c_out        = 1'b0;
    done         = 1'b0;
    done_id      = '0;
    case (r_state)
      IDLE: begin
        // The state register is already IDLE under reset, so the only
        // thing to suppress while rst_n is low is the accept pulse.
        req_ready = rst_n ? w_gnt : '0;
        if (w_any) w_state_next = SETUP;
      end
      SETUP: begin
        s_out        = (r_op == OP_SET) ? w_vec : '0;
        r_out        = (r_op == OP_SET) ? '0 : w_vec;
        w_state_next = PULSE;
      end
      PULSE: begin
        s_out = (r_op == OP_SET) ? w_vec : '0;
        r_out = (r_op == OP_SET) ? '0 : w_vec;
        c_out = 1'b1;
        if (r_cnt == '0) w_state_next = HOLD;
      end
      HOLD: begin
        // Data held one more cycle so it is stable as the gate falls.
        s_out        = (r_op == OP_SET) ? w_vec : '0;
        r_out        = (r_op == OP_SET) ? '0 : w_vec;
        w_state_next = CHECK;
      end
      CHECK: begin
        done         = 1'b1;
        done_id      = r_gid;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= r_err | w_mis;
      if (r_state == IDLE && w_any) begin
        r_op  <= req_op[w_gnt_idx];
        r_idx <= req_idx[int'(w_gnt_idx)*IW +: IW];
        r_gid <= w_gnt_idx;
        r_ptr <= (w_gnt_idx == GW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end
      // Counter loaded on the way into PULSE, expires after PULSE_CYC cycles.
      if (r_state == SETUP)      r_cnt <= 4'(PULSE_CYC-1);
      else if (r_state == PULSE) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: doc/sr_flag_sched.md
Name: sr_flag_sched

Overview:
- Scheduler for a shared bank of NFLAG gated SR flip-flops: each flop has set `s`, reset `r`, and a shared gate/enable `c`.
- NREQ requesters ask to set or clear one flag each; the block arbitrates round-robin and serialises the operations.
- For each operation it generates a legal s/r/c pulse sequence (never S=R=1), then reads back the flop Q to confirm the write.
- Sits between the control logic and the SR flag bank.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR flops in the bank (power of 2, 2..16)
- PULSE_CYC, 2, cycles the gate `c` is held high per operation (1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_op  input  NREQ  per-requester op: 1=set, 0=reset
- req_idx  input  NREQ*$clog2(NFLAG)  per-requester flag index, packed, requester 0 in the LSBs
- req_ready  output  NREQ  one-hot, 1-cycle accept pulse
- s_out  output  NFLAG  set lines to the bank
- r_out  output  NFLAG  reset lines to the bank
- c_out  output  1  gate/enable to the bank
- q_in  input  NFLAG  Q readback from the bank
- done  output  1  1-cycle completion pulse
- done_id  output  $clog2(NREQ)  requester whose operation completed; valid with done
- err  output  1  sticky readback-mismatch flag
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE, rr pointer=0.
  - s_out=0, r_out=0, c_out=0, req_ready=0, done=0, done_id=0, err=0, busy=0.
  - An operation cut off by reset is dropped; no done pulse is issued for it.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the pointer, wrapping modulo NREQ.
  - Pulse req_ready[g] for this cycle only, latch op, idx and g, move to SETUP.
  - Update pointer to (g+1) mod NREQ. The pointer does not change when there is no grant.
- SETUP (1 cycle): drive s_out[idx]=op, r_out[idx]=~op, all other bits 0, c_out=0.
- PULSE (PULSE_CYC cycles): s/r held, c_out=1; a down-counter sets the duration.
- HOLD (1 cycle): c_out=0, s/r still held, so data is stable across the falling gate edge.
- CHECK (1 cycle):
  - s_out=r_out=0, c_out=0, done=1, done_id=g.
  - If q_in[idx] != op, set err; err stays set until reset.
  - Next state is IDLE.
- Latency: accept at cycle T, done at cycle T+PULSE_CYC+3; next accept no earlier than T+PULSE_CYC+4.
- Invariants (assertion targets):
  - s_out & r_out == 0 in every cycle.
  - At most one bit set across s_out|r_out.
  - c_out high only in PULSE.
  - req_ready is one-hot or zero, and zero outside IDLE.
- Requester contract: hold req_valid, req_op and req_idx stable until req_ready. Inputs change only while that requester is not being granted; the latched copies make the block immune to input changes after acceptance.
- A requester whose req_valid drops before grant is skipped with no side effect.
- Redundant ops (set an already-set flag) are still executed in full.
- Arithmetic: the index is used modulo NFLAG. No overflow is possible since NFLAG is a power of 2.

Decomposition:
- Package sr_sched_pkg: state enum (IDLE, SETUP, PULSE, HOLD, CHECK), op constants OP_SET=1'b1 and OP_RST=1'b0, default parameter constants.
- Sub-module rr_arbiter: inputs NREQ request vector and pointer; outputs one-hot grant and encoded index; purely combinational.
- The pointer register and FSM live in sr_flag_sched.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111 -> all outputs 0, no req_ready. Assert rst_n=0 during PULSE -> c_out, s_out and r_out drop to 0 asynchronously, no done.
- Single set, PULSE_CYC=2: req_valid[1]=1, op=1, idx=5 at cycle 0 -> req_ready=4'b0010 at cycle 0; s_out=8'h20 cycles 1-4; c_out=1 cycles 2-3; done=1, done_id=1 at cycle 5. Model q_in[5]=1 -> err=0.
- Round-robin fairness: all four requesters valid continuously -> grant order 0,1,2,3,0; one grant every 6 cycles.
- Mismatch: set flag 3 with model q_in[3] stuck at 0 -> err=1 at the CHECK cycle, still 1 after later good operations.
- Set then reset on the same index: r0 sets idx 2, r2 resets idx 2 -> s_out=8'h04 in the first operation, r_out=8'h04 in the second, never both. Final q_in[2]=0 with err=0.
- Withdrawn request: r2 valid for 1 cycle during busy, then dropped -> never granted, pointer skips it, no done with done_id=2.
